irom_sram_ctrl: RTL and testbench

- Responder side of the instruction-fetch ROM interface.
- Accepts `read_ce` and a byte address from the fetch stage, then drives two 16-bit asynchronous SRAM chips in parallel (chip A holds the low half-word, chip B the high half-word).
- Waits a programmable number of cycles per chip, latches the 32-bit instruction, and raises per-chip completion flags `rfin_c`/`rfin_d`.
- Sits between the fetch stage and the board instruction SRAM; read-only.

---
 rtl/irom_sram_ctrl_if.sv | 15 +
 rtl/irom_sram_ctrl.sv | 84 ++++++++
 tb/tb_irom_sram_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/irom_sram_ctrl_if.sv
// irom_sram_ctrl_if: instruction-fetch ROM bus between the fetch stage (master) and the SRAM responder (slave)
//   read_ce   fetch request, held while the instruction is wanted
//   irom_addr word-aligned byte address
//   rom_inst  latched instruction {chip B, chip A}
//   rfin_c    low half-word valid for the current address
//   rfin_d    high half-word valid for the current address
interface irom_sram_ctrl_if;
  logic        read_ce;
  logic [31:0] irom_addr;
  logic [31:0] rom_inst;
  logic        rfin_c;
  logic        rfin_d;
  modport master (output read_ce, irom_addr, input rom_inst, rfin_c, rfin_d);
  modport slave (input read_ce, irom_addr, output rom_inst, rfin_c, rfin_d);
endinterface

// File: rtl/irom_sram_ctrl.sv
// irom_sram_ctrl: read-only responder fetching a 32-bit instruction from two parallel 16-bit async SRAMs
//   clk/rst          clock, async active-high reset
//   bus              fetch-side interface (slave modport)
//   sram_addr_o      word address shared by both chips
//   sram_ce_n_o/oe_n_o/we_n_o  shared active-low strobes, write enable tied inactive
//   sram_data_a_i/b_i  chip A (low half) and chip B (high half) data
module irom_sram_ctrl #(
  parameter int ADDR_W = 20,
  parameter int WAIT_A = 2,
  parameter int WAIT_B = 2
) (
  input  logic              clk,
  input  logic              rst,
  irom_sram_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  input  logic [15:0]       sram_data_a_i,
  input  logic [15:0]       sram_data_b_i
);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;
  localparam logic [3:0] WA = 4'(WAIT_A);
  localparam logic [3:0] WB = 4'(WAIT_B);
  localparam logic [3:0] WM = (WA > WB) ? WA : WB;
  state_t            state_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       inst_q;
  logic              rfin_c_q, rfin_d_q, ce_n_q, oe_n_q;
  logic [ADDR_W-1:0] word_addr;
  logic              addr_chg;
  logic              unused_bits;
  assign word_addr   = bus.irom_addr[ADDR_W+1:2];
  assign unused_bits = ^{bus.irom_addr[31:ADDR_W+2], bus.irom_addr[1:0]};
  assign addr_chg    = word_addr != addr_q;
  assign cnt_d       = cnt_q + {3'd0, cnt_q != 4'hf};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      inst_q   <= '0;
      rfin_c_q <= 1'b0;
      rfin_d_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else if (!bus.read_ce) begin
      state_q  <= IDLE;
      rfin_c_q <= 1'b0;
      rfin_d_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else if (state_q == IDLE || addr_chg) begin
      state_q  <= SETUP;
      addr_q   <= word_addr;
      cnt_q    <= '0;
      rfin_c_q <= 1'b0;
      rfin_d_q <= 1'b0;
      ce_n_q   <= 1'b0;
      oe_n_q   <= 1'b0;
    end else if (state_q == SETUP) begin
      state_q <= WAIT;
      cnt_q   <= 4'd1;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_d;
      if (cnt_q == WA) begin
        inst_q[15:0] <= sram_data_a_i;
        rfin_c_q     <= 1'b1;
      end
      if (cnt_q == WB) begin
        inst_q[31:16] <= sram_data_b_i;
        rfin_d_q      <= 1'b1;
      end
      if (cnt_q == WM) state_q <= DONE;
    end
  assign bus.rom_inst = inst_q;
  assign bus.rfin_c   = rfin_c_q;
  assign bus.rfin_d   = rfin_d_q;
  assign sram_addr_o  = addr_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = 1'b1;
endmodule

// File: tb/tb_irom_sram_ctrl.sv
// tb_irom_sram_ctrl: scoreboard bench for irom_sram_ctrl with equal and unequal chip waits
module tb_irom_sram_ctrl;
  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] inst;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  irom_sram_ctrl_if f0 ();
  irom_sram_ctrl_if f1 ();
  logic [19:0] sa0, sa1;
  logic        ce0, oe0, we0, ce1, oe1, we1;
  logic [31:0] w0, w1;
  function automatic logic [31:0] mem(input logic [19:0] a);
    case (a)
      20'd4:   mem = 32'h1234_5678;
      20'd5:   mem = 32'h9ABC_DEF0;
      20'd7:   mem = 32'h4444_3333;
      default: mem = 32'hDDDD_EEEE;
    endcase
  endfunction
  assign w0 = mem(sa0);
  assign w1 = mem(sa1);
  irom_sram_ctrl dut0 (
    .clk(clk), .rst(rst), .bus(f0.slave),
    .sram_addr_o(sa0), .sram_ce_n_o(ce0), .sram_oe_n_o(oe0), .sram_we_n_o(we0),
    .sram_data_a_i(w0[15:0]), .sram_data_b_i(w0[31:16])
  );
  irom_sram_ctrl #(.ADDR_W(20), .WAIT_A(1), .WAIT_B(3)) dut1 (
    .clk(clk), .rst(rst), .bus(f1.slave),
    .sram_addr_o(sa1), .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1),
    .sram_data_a_i(w1[15:0]), .sram_data_b_i(w1[31:16])
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  always @(negedge clk) begin
    logic b0, b1;
    exp_t e;
    b0 = f0.rfin_c & f0.rfin_d;
    b1 = f1.rfin_c & f1.rfin_d;
    if (b0 && !prev0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon0_unexpected: got inst %h with empty queue", f0.rom_inst);
      end else begin
        e = q0.pop_front();
        check("mon0_inst", f0.rom_inst, e.inst);
        check("mon0_addr", {12'd0, sa0}, {12'd0, e.addr});
      end
    end
    if (b1 && !prev1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon1_unexpected: got inst %h with empty queue", f1.rom_inst);
      end else begin
        e = q1.pop_front();
        check("mon1_inst", f1.rom_inst, e.inst);
        check("mon1_addr", {12'd0, sa1}, {12'd0, e.addr});
      end
    end
    prev0 = b0;
    prev1 = b1;
  end
  always @(negedge clk) if (we0 !== 1'b1 || we1 !== 1'b1) check("we_n_high", {31'd0, we0 & we1}, 32'd1);
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    f0.read_ce = 1'b0; f0.irom_addr = '0;
    f1.read_ce = 1'b0; f1.irom_addr = '0;
    step(2);
    check("rst_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    check("rst_inst", f0.rom_inst, 32'd0);
    check("rst_ce_oe", {30'd0, ce0, oe0}, 32'd3);
    check("rst_addr", {12'd0, sa0}, 32'd0);
    rst = 1'b0;
    step(1);
    // basic fetch
    f0.read_ce = 1'b1; f0.irom_addr = 32'h10;
    q0.push_back('{addr: 20'd4, inst: 32'h1234_5678});
    step(1);
    check("bf_addr", {12'd0, sa0}, 32'd4);
    check("bf_ce_oe_setup", {30'd0, ce0, oe0}, 32'd0);
    step(1);
    check("bf_rfin_e1", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    step(1);
    check("bf_rfin_e2", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    step(1);
    check("bf_rfin_e3", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    check("bf_inst", f0.rom_inst, 32'h1234_5678);
    step(2);
    check("bf_hold_inst", f0.rom_inst, 32'h1234_5678);
    check("bf_hold_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    // byte-offset-only change is not a restart
    f0.irom_addr = 32'h12;
    step(2);
    check("bo_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    check("bo_addr", {12'd0, sa0}, 32'd4);
    // address change in DONE
    f0.irom_addr = 32'h14;
    q0.push_back('{addr: 20'd5, inst: 32'h9ABC_DEF0});
    step(1);
    check("ac_rfin_drop", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    check("ac_addr", {12'd0, sa0}, 32'd5);
    check("ac_inst_kept", f0.rom_inst, 32'h1234_5678);
    step(2);
    check("ac_rfin_e2", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    step(1);
    check("ac_rfin_e3", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    check("ac_inst", f0.rom_inst, 32'h9ABC_DEF0);
    // request drop in WAIT at counter 1
    f0.irom_addr = 32'h1C;
    step(2);
    f0.read_ce = 1'b0;
    step(1);
    check("rd_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    check("rd_inst", f0.rom_inst, 32'h9ABC_DEF0);
    check("rd_ce_oe", {30'd0, ce0, oe0}, 32'd3);
    step(2);
    check("rd_rfin_stay", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    // fetch word 7 then simultaneous change+drop
    f0.read_ce = 1'b1;
    q0.push_back('{addr: 20'd7, inst: 32'h4444_3333});
    step(4);
    check("w7_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    f0.read_ce = 1'b0; f0.irom_addr = 32'h10;
    step(1);
    check("sim_ce_oe", {30'd0, ce0, oe0}, 32'd3);
    check("sim_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    check("sim_inst", f0.rom_inst, 32'h4444_3333);
    f0.read_ce = 1'b1;
    q0.push_back('{addr: 20'd4, inst: 32'h1234_5678});
    step(1);
    check("sim_restart_addr", {12'd0, sa0}, 32'd4);
    check("sim_restart_ce", {30'd0, ce0, oe0}, 32'd0);
    step(3);
    check("sim_restart_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd3);
    // reset mid-WAIT
    f0.irom_addr = 32'h14;
    step(3);
    #2 rst = 1'b1;
    #1;
    check("mrst_rfin", {30'd0, f0.rfin_c, f0.rfin_d}, 32'd0);
    check("mrst_inst", f0.rom_inst, 32'd0);
    check("mrst_ce_oe", {30'd0, ce0, oe0}, 32'd3);
    check("mrst_addr", {12'd0, sa0}, 32'd0);
    f0.read_ce = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    // unequal waits: A=1, B=3
    f1.read_ce = 1'b1; f1.irom_addr = 32'h10;
    q1.push_back('{addr: 20'd4, inst: 32'h1234_5678});
    step(2);
    check("uw_rfin_e1", {30'd0, f1.rfin_c, f1.rfin_d}, 32'd0);
    step(1);
    check("uw_rfin_e2", {30'd0, f1.rfin_c, f1.rfin_d}, 32'd2);
    check("uw_inst_e2", f1.rom_inst, 32'h0000_5678);
    step(1);
    check("uw_rfin_e3", {30'd0, f1.rfin_c, f1.rfin_d}, 32'd2);
    step(1);
    check("uw_rfin_e4", {30'd0, f1.rfin_c, f1.rfin_d}, 32'd3);
    check("uw_inst_e4", f1.rom_inst, 32'h1234_5678);
    step(2);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
